rs_syndrome_calc: RTL and testbench

First stage of the RS(255,239) decoder. Accepts received codewords one symbol per valid cycle, in the same order the encoder emits them (first symbol = coefficient of x^254, last parity = x^0). Computes the 16 syndromes S_i = r(α^i), i = 0..15, over GF(2^8) with α = 0x02 and p(x) = x^8+x^4+x^3+x^2+1. Presents them with a one-cycle valid strobe and an error flag to the downstream key-equation solver.

---
 rtl/rs_syndrome_calc.sv | 144 ++++++++++++++
 tb/tb_rs_syndrome_calc.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_syndrome_calc.sv
// rs_syndrome_calc -- syndrome stage of the RS(255,239) decoder.
//
// Received symbols arrive highest-degree first. One Horner accumulator per root
// alpha^i (i = 0..NSYM-1) evaluates r(alpha^i) over GF(2^8), with
// p(x) = x^8+x^4+x^3+x^2+1. When the N-th symbol of a codeword is accepted, the
// final Horner values are registered straight into synd_out, together with an
// any-nonzero error flag and a one-cycle synd_valid pulse.
//
// Ports:
//   clk_in      clock
//   sys_rst_n   asynchronous active-low reset
//   code_valid  code_in carries a symbol this cycle
//   code_sof    with code_valid: the symbol starts a new codeword
//   code_in     received symbol (8 bits)
//   busy        a codeword is partially received
//   synd_valid  one-cycle pulse: synd_out / err_flag were just updated
//   synd_out    S_i at bits [8i+7:8i]
//   err_flag    1 if any syndrome of the last completed codeword is nonzero

// One accumulator lane: acc <= acc * alpha^POW ^ code_in.
module rs_synd_lane #(
    parameter int POW = 0
) (
    input  logic       clk_in,
    input  logic       sys_rst_n,
    input  logic       load,      // first symbol: acc takes code_in as-is
    input  logic       step,      // continuation symbol: Horner update
    input  logic [7:0] code_in,
    output logic [7:0] horner     // acc * alpha^POW ^ code_in, for the completion path
);
    // Multiply by alpha (x) modulo 0x11D.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    endfunction

    // The constant multiply unrolls into a fixed XOR network at elaboration.
    function automatic logic [7:0] mul_alpha_pow(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int k = 0; k < POW; k++) r = xtime(r);
        return r;
    endfunction

    logic [7:0] acc_q, acc_d;

    assign horner = mul_alpha_pow(acc_q) ^ code_in;

    always_comb begin
        acc_d = acc_q;
        if (load)      acc_d = code_in;
        else if (step) acc_d = horner;
    end

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) acc_q <= 8'h00;
        else            acc_q <= acc_d;
    end
endmodule

module rs_syndrome_calc #(
    parameter int N    = 255,  // symbols per codeword, 2..255
    parameter int NSYM = 16    // number of syndromes
) (
    input  logic                clk_in,
    input  logic                sys_rst_n,
    input  logic                code_valid,
    input  logic                code_sof,
    input  logic [7:0]          code_in,
    output logic                busy,
    output logic                synd_valid,
    output logic [8*NSYM-1:0]   synd_out,
    output logic                err_flag
);
    // Counter value held just before the final symbol is accepted.
    localparam logic [7:0] LAST_CNT = 8'(N - 1);

    logic                      load, step, last;
    logic [NSYM-1:0][7:0]      synd_horner;

    logic [7:0]                cnt_q, cnt_d;
    logic                      busy_q, busy_d;
    logic                      synd_valid_q, synd_valid_d;
    logic [NSYM-1:0][7:0]      synd_out_q, synd_out_d;
    logic                      err_flag_q, err_flag_d;

    // A sof restarts unconditionally, dropping any partial word. Non-sof
    // symbols only count while a word is open; stray ones while idle vanish.
    assign load = code_valid & code_sof;
    assign step = code_valid & ~code_sof & busy_q;
    assign last = step & (cnt_q == LAST_CNT);

    for (genvar g = 0; g < NSYM; g++) begin : g_lane
        rs_synd_lane #(.POW(g)) u_lane (
            .clk_in    (clk_in),
            .sys_rst_n (sys_rst_n),
            .load      (load),
            .step      (step),
            .code_in   (code_in),
            .horner    (synd_horner[g])
        );
    end

    always_comb begin
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        synd_out_d   = synd_out_q;
        err_flag_d   = err_flag_q;
        synd_valid_d = last;
        if (load) begin
            cnt_d  = 8'd1;
            busy_d = 1'b1;
        end else if (last) begin
            // Final Horner result bypasses the accumulators into the output
            // register so the syndromes appear one cycle after the last symbol.
            cnt_d      = 8'd0;
            busy_d     = 1'b0;
            synd_out_d = synd_horner;
            err_flag_d = |synd_horner;
        end else if (step) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q        <= 8'd0;
            busy_q       <= 1'b0;
            synd_valid_q <= 1'b0;
            synd_out_q   <= '0;
            err_flag_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            synd_valid_q <= synd_valid_d;
            synd_out_q   <= synd_out_d;
            err_flag_q   <= err_flag_d;
        end
    end

    assign busy       = busy_q;
    assign synd_valid = synd_valid_q;
    assign synd_out   = synd_out_q;
    assign err_flag   = err_flag_q;
endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Self-checking bench for rs_syndrome_calc: a scoreboard queue of expected
// syndrome sets, a table of single-symbol codewords with hand-computed results,
// an RS(255,239) encoder built in the bench, and hand sequences for restart,
// idle, back-to-back and mid-frame reset.
module tb_rs_syndrome_calc;
    localparam int N    = 255;
    localparam int NSYM = 16;
    localparam int K    = N - NSYM;

    logic                clk_in = 1'b0;
    logic                sys_rst_n;
    logic                code_valid, code_sof;
    logic [7:0]          code_in;
    logic                busy, synd_valid, err_flag;
    logic [8*NSYM-1:0]   synd_out;

    rs_syndrome_calc #(.N(N), .NSYM(NSYM)) dut (
        .clk_in     (clk_in),
        .sys_rst_n  (sys_rst_n),
        .code_valid (code_valid),
        .code_sof   (code_sof),
        .code_in    (code_in),
        .busy       (busy),
        .synd_valid (synd_valid),
        .synd_out   (synd_out),
        .err_flag   (err_flag)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [NSYM-1:0][7:0] s;
        logic                 e;
    } exp_t;

    typedef struct {
        int                   deg;   // degree of the single nonzero symbol
        logic [7:0]           val;
        logic [NSYM-1:0][7:0] s;
        logic                 e;
    } vec_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          pulses = 0;
    int          pushes = 0;
    logic [7:0]  cw   [0:N-1];   // cw[k] is the coefficient of x^(N-1-k)
    logic [7:0]  apow [0:254];
    logic [7:0]  gen  [0:NSYM];

    task automatic chk(input string name, input logic [8*NSYM-1:0] act, input logic [8*NSYM-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1D) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    // Direct evaluation r(alpha^i) = sum cw[k] * alpha^(i*deg_k).
    function automatic exp_t model_synd();
        exp_t r;
        r.s = '0;
        for (int i = 0; i < NSYM; i++)
            for (int k = 0; k < N; k++)
                r.s[i] = r.s[i] ^ gf_mul(cw[k], apow[(i * (N - 1 - k)) % 255]);
        r.e = |r.s;
        return r;
    endfunction

    // Scoreboard consumer: every pulse must match the oldest expectation.
    always @(negedge clk_in) begin
        if (sys_rst_n === 1'b1 && synd_valid === 1'b1) begin
            exp_t x;
            pulses++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got synd_valid=1 expected 0 (synd=%h)", synd_out);
            end else begin
                x = sb_q.pop_front();
                chk("synd_out", synd_out, x.s);
                chk("err_flag", {127'd0, err_flag}, {127'd0, x.e});
            end
        end
    end

    task automatic cyc(input logic v, input logic s, input logic [7:0] d);
        code_valid = v;
        code_sof   = s;
        code_in    = d;
        @(posedge clk_in);
        #1;
    endtask

    // Feed cw[] as a full frame; gap_at[k] idle cycles precede symbol k.
    task automatic send_frame(input exp_t e, input int ngaps);
        int gap_at [0:N-1];
        int placed;
        for (int k = 0; k < N; k++) gap_at[k] = 0;
        placed = 0;
        while (placed < ngaps) begin
            int p;
            p = $urandom_range(N - 1, 1);
            if (gap_at[p] == 0) begin
                gap_at[p] = $urandom_range(4, 1);
                placed++;
            end
        end
        for (int k = 0; k < N; k++) begin
            for (int g = 0; g < gap_at[k]; g++) cyc(1'b0, 1'b0, 8'($urandom));
            if (k == N - 1) begin
                sb_q.push_back(e);
                pushes++;
            end
            cyc(1'b1, k == 0, cw[k]);
            if (k == 10) chk("busy_in_frame", {127'd0, busy}, {127'd0, 1'b1});
        end
        code_valid = 1'b0;
        chk("busy_after_frame", {127'd0, busy}, 128'd0);
    endtask

    task automatic zero_cw();
        for (int k = 0; k < N; k++) cw[k] = 8'h00;
    endtask

    task automatic encode_cw(input int seed_mode);
        logic [7:0] rem [0:NSYM-1];
        logic [7:0] fb;
        for (int j = 0; j < NSYM; j++) rem[j] = 8'h00;
        for (int k = 0; k < K; k++) begin
            cw[k] = (seed_mode == 0) ? 8'(k + 1) : 8'($urandom);
            fb = cw[k] ^ rem[NSYM-1];
            for (int j = NSYM - 1; j > 0; j--) rem[j] = rem[j-1] ^ gf_mul(fb, gen[j]);
            rem[0] = gf_mul(fb, gen[0]);
        end
        for (int j = 0; j < NSYM; j++) cw[K + j] = rem[NSYM - 1 - j];
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb_q.size() != 0 && budget < 20) begin
            @(posedge clk_in);
            budget++;
        end
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    vec_t vecs [0:4];
    exp_t zero_e, e;

    initial begin
        // Tables
        apow[0] = 8'h01;
        for (int k = 1; k < 255; k++) apow[k] = gf_mul(apow[k-1], 8'h02);
        gen[0] = 8'h01;
        for (int j = 1; j <= NSYM; j++) gen[j] = 8'h00;
        for (int r = 0; r < NSYM; r++) begin
            for (int j = NSYM; j > 0; j--) gen[j] = gen[j-1] ^ gf_mul(gen[j], apow[r]);
            gen[0] = gf_mul(gen[0], apow[r]);
        end
        zero_e = '0;

        vecs[0] = '{0, 8'h5A, {NSYM{8'h5A}}, 1'b1};
        vecs[1] = '{1, 8'h01, {8'h26, 8'h13, 8'h87, 8'hCD, 8'hE8, 8'h74, 8'h3A, 8'h1D,
                               8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01}, 1'b1};
        vecs[2] = '{2, 8'h01, {8'h60, 8'h18, 8'h06, 8'h8F, 8'hEA, 8'hB4, 8'h2D, 8'h4C,
                               8'h13, 8'hCD, 8'h74, 8'h1D, 8'h40, 8'h10, 8'h04, 8'h01}, 1'b1};
        vecs[3] = '{0, 8'h00, {NSYM{8'h00}}, 1'b0};
        vecs[4] = '{0, 8'hFF, {NSYM{8'hFF}}, 1'b1};

        // Reset state
        sys_rst_n  = 1'b0;
        code_valid = 1'b0;
        code_sof   = 1'b0;
        code_in    = 8'h00;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_synd_valid", {127'd0, synd_valid}, 128'd0);
        chk("rst_synd_out", synd_out, 128'd0);
        chk("rst_err_flag", {127'd0, err_flag}, 128'd0);
        @(negedge clk_in);
        sys_rst_n = 1'b1;
        @(posedge clk_in);
        #1;

        // All-zero codeword, no gaps
        zero_cw();
        send_frame(zero_e, 0);
        drain();

        // Encoder output for data 1..239 with 17 gaps
        begin
            int p0;
            encode_cw(0);
            p0 = pulses;
            send_frame(zero_e, 17);
            drain();
            chk("encoded_one_pulse", 128'(pulses - p0), 128'd1);
        end

        // Single-symbol codewords with hand-computed syndromes, back to back
        for (int v = 0; v < 5; v++) begin
            exp_t x;
            zero_cw();
            cw[N - 1 - vecs[v].deg] = vecs[v].val;
            x.s = vecs[v].s;
            x.e = vecs[v].e;
            send_frame(x, 0);
        end
        drain();

        // Idle non-sof symbols are ignored: outputs keep the 0xFF result
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 8'($urandom_range(255, 1)));
        code_valid = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("idle_busy", {127'd0, busy}, 128'd0);
        chk("idle_synd_hold", synd_out, {NSYM{8'hFF}});
        chk("idle_err_hold", {127'd0, err_flag}, 128'd1);

        // 100 symbols of a word, then a restart with a full zero codeword
        cyc(1'b1, 1'b1, 8'hA5);
        for (int k = 1; k < 100; k++) cyc(1'b1, 1'b0, 8'($urandom_range(255, 1)));
        zero_cw();
        send_frame(zero_e, 3);
        drain();

        // Random encoded codeword, then a random corrupted one (model-checked)
        encode_cw(1);
        send_frame(zero_e, 5);
        encode_cw(1);
        cw[$urandom_range(N - 1, 0)] ^= 8'($urandom_range(255, 1));
        e = model_synd();
        send_frame(e, 0);
        drain();
        zero_cw();
        cw[N - 1] = 8'h5A;
        send_frame(vecs[0].s == {NSYM{8'h5A}} ? '{s: {NSYM{8'h5A}}, e: 1'b1} : zero_e, 0);
        drain();

        // Reset at symbol 50 of a frame
        encode_cw(1);
        for (int k = 0; k < 50; k++) cyc(1'b1, k == 0, cw[k]);
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_busy", {127'd0, busy}, 128'd0);
        chk("midrst_synd_out", synd_out, 128'd0);
        chk("midrst_err_flag", {127'd0, err_flag}, 128'd0);
        code_valid = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        sys_rst_n = 1'b1;
        @(posedge clk_in);
        #1;
        zero_cw();
        cw[N - 2] = 8'h01;
        cw[N - 1] = 8'h33;
        e = model_synd();
        send_frame(e, 2);
        drain();

        chk("total_pulses", 128'(pulses), 128'(pushes));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
